// File: rtl/parity_tx_if.sv
// Byte-load / serial-out handshake between a frame producer and parity_tx.
interface parity_tx_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              ready;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output data_in, load,
        input  ready, tx, busy, done
    );

    modport slave (
        input  data_in, load,
        output ready, tx, busy, done
    );
endinterface

// File: rtl/parity_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, parity bit, stop bit,
// each held BIT_CYCLES clocks. All outputs come straight from flops.
module parity_tx #(
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    parity_tx_if.slave  bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(BIT_CYCLES - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;
    logic [IDX_W-1:0]    idx_nxt;

    // The done/IDLE cycle supplies the final stop-bit clock, so a load taken
    // there starts the next frame with no gap and frames stay 11*BIT_CYCLES.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        bit_end = (cyc_q == LAST_CYC);
        idx_nxt = IDX_W'(idx_q + IDX_W'(1));

        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : CNT_W'(cyc_q + CNT_W'(1));
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
                if (bus.load) begin
                    state_d = START;
                    data_d  = bus.data_in;
                    cyc_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                        idx_d   = '0;
                        tx_d    = (^data_q) ^ ODD_BIT;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d = 1'b1;
                    if (BIT_CYCLES == 1) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Stop count starts at 1: the done cycle is its last clock.
                        state_d = STOP;
                        cyc_d   = CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_parity_tx.sv
// Scoreboard bench: lane 0 = even parity, 4 clocks/bit; lane 1 = odd parity, 1 clock/bit.
module tb_parity_tx;
    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst_v;
    logic [7:0] din [2];
    logic [1:0] ld;
    wire  [1:0] rdy_w, tx_w, busy_w, done_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int l, input logic act, input logic want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s lane%0d got %b want %b at %0t", nm, l, act, want, $time);
        end
    endtask

    function automatic logic exp_bit(input exp_t e, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.d[k-1];
        if (k == 9) return e.p;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int BC = (g == 0) ? 4 : 1;
        parity_tx_if bus ();
        parity_tx #(.PARITY_ODD(g), .BIT_CYCLES(BC)) dut (
            .clk (clk),
            .rst (rst_v[g]),
            .bus (bus)
        );
        assign bus.data_in = din[g];
        assign bus.load    = ld[g];
        assign rdy_w[g]    = bus.ready;
        assign tx_w[g]     = bus.tx;
        assign busy_w[g]   = bus.busy;
        assign done_w[g]   = bus.done;

        exp_t q [$];
        exp_t cur;
        bit   active = 1'b0;
        int   cnt    = 0;
        logic last;

        // Monitor: pops one expectation per frame and checks every frame clock.
        always @(negedge clk) begin
            if (rst_v[g]) begin
                active = 1'b0;
                q.delete();
            end else begin
                if (!active && bus.busy) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame", g, 1'b1, 1'b0);
                    end else begin
                        cur    = q.pop_front();
                        active = 1'b1;
                        cnt    = 0;
                    end
                end
                if (active) begin
                    last = (cnt == 11*BC - 1);
                    check("frame_tx", g, bus.tx, exp_bit(cur, cnt / BC));
                    check("frame_done", g, bus.done, last);
                    check("frame_ready", g, bus.ready, last);
                    check("frame_busy", g, bus.busy, !last);
                    if (last) active = 1'b0;
                    else      cnt++;
                end else begin
                    check("idle_tx", g, bus.tx, 1'b1);
                    check("idle_ready", g, bus.ready, 1'b1);
                    check("idle_done", g, bus.done, 1'b0);
                end
            end
        end
    end

    task automatic push(input int l, input exp_t e);
        if (l == 0) lane[0].q.push_back(e);
        else        lane[1].q.push_back(e);
    endtask

    // Called at a negedge; waits for ready, then holds load for one edge.
    task automatic send(input int l, input logic [7:0] d, input logic p);
        int   n = 0;
        exp_t e;
        while (rdy_w[l] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", l, 1'b0, 1'b1);
        end else begin
            e.d = d;
            e.p = p;
            din[l] = d;
            ld[l]  = 1'b1;
            push(l, e);
            @(negedge clk);
            ld[l] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string nm, input int l);
        check({nm, "_tx"}, l, tx_w[l], 1'b1);
        check({nm, "_ready"}, l, rdy_w[l], 1'b1);
        check({nm, "_busy"}, l, busy_w[l], 1'b0);
        check({nm, "_done"}, l, done_w[l], 1'b0);
    endtask

    task automatic lane0_seq();
        exp_t e;
        logic [7:0] b;
        send(0, 8'hA5, 1'b0);
        repeat (9) @(negedge clk);
        din[0] = 8'hFF;
        ld[0]  = 1'b1;
        check("busy_load_ready", 0, rdy_w[0], 1'b0);
        @(negedge clk);
        ld[0] = 1'b0;
        send(0, 8'h01, 1'b1);
        send(0, 8'h96, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_v[0] = 1'b1;
        #1 check_reset_outputs("midframe_rst", 0);
        repeat (3) @(negedge clk);
        #1;
        rst_v[0] = 1'b0;
        din[0]   = 8'h5A;
        ld[0]    = 1'b1;
        e.d = 8'h5A;
        e.p = 1'b0;
        push(0, e);
        @(negedge clk);
        ld[0] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send(0, b, ^b);
        end
    endtask

    task automatic lane1_seq();
        int n = 0;
        int pushed;
        exp_t e;
        logic [7:0] b;
        send(1, 8'h01, 1'b0);
        send(1, 8'h00, 1'b1);
        while (rdy_w[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready", 1, rdy_w[1], 1'b1);
        din[1] = 8'h3C;
        ld[1]  = 1'b1;
        e.d = 8'h3C;
        e.p = 1'b1;
        push(1, e);
        pushed = 1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check("b2b_done", 1, done_w[1], (c == 10 || c == 21));
            if (rdy_w[1] === 1'b1) begin
                if (pushed == 1) begin
                    din[1] = 8'hC3;
                    e.d = 8'hC3;
                    e.p = 1'b1;
                    push(1, e);
                    pushed = 2;
                end else if (pushed == 2) begin
                    ld[1]  = 1'b0;
                    pushed = 3;
                end
            end
        end
        ld[1] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send(1, b, ~^b);
        end
    endtask

    initial begin
        rst_v  = 2'b11;
        ld     = 2'b00;
        din[0] = 8'h00;
        din[1] = 8'h00;
        #1;
        check_reset_outputs("por", 0);
        check_reset_outputs("por", 1);
        repeat (3) @(negedge clk);
        rst_v = 2'b00;
        @(negedge clk);
        fork
            lane0_seq();
            lane1_seq();
        join
        repeat (60) @(negedge clk);
        check("drain_q0", 0, lane[0].q.size() == 0, 1'b1);
        check("drain_q1", 1, lane[1].q.size() == 0, 1'b1);
        check("drain_act0", 0, lane[0].active, 1'b0);
        check("drain_act1", 1, lane[1].active, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
